// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared FSM states and digit constants for the keypad entry
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] DIGIT_CLR = 4'h0;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DEB_PRESS = 2'd1,
    S_HELD      = 2'd2,
    S_DEB_REL   = 2'd3
  } state_t;

endpackage : keypad_pkg
`default_nettype wire

// File: rtl/keypad_digit_entry_onehot_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : onehot_to_bin
//  Description : Encodes a captured key pattern to a 4-bit digit value and
//                flags patterns that are not exactly one-hot
//  Revision    : 1.0 - initial release
// ============================================================================
module onehot_to_bin
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS = 10
) (
  input  logic [NUM_KEYS-1:0] i_cand,
  output logic [DIGIT_W-1:0]  o_value,
  output logic                o_onehot
);

  logic w_seen;
  logic w_multi;

  // OR-ing indices yields the exact index when only one bit is set
  always_comb begin
    o_value = '0;
    w_seen  = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (i_cand[i]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen  = 1'b1;
        o_value = o_value | DIGIT_W'(i);
      end
    end
    o_onehot = w_seen & ~w_multi;
  end

endmodule : onehot_to_bin
`default_nettype wire

// File: rtl/keypad_digit_entry.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_digit_entry
//  Description : Debounced one-hot keypad to shifting BCD/hex digit register
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_digit_entry
  import keypad_pkg::*;
#(
  parameter int NUM_KEYS        = 10,
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_KEYS-1:0]          keys,
  input  logic                         en,
  input  logic                         clr,
  output logic [DIGIT_W*DIGITS-1:0]    digits,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         full,
  output logic                         dv,
  output logic                         err
);

  localparam int c_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_COUNT_W = $clog2(DIGITS+1);
  localparam int c_REG_W   = DIGIT_W * DIGITS;

  localparam logic [c_CNT_W-1:0]   c_DEB_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_COUNT_W-1:0] c_FULL_CNT = c_COUNT_W'(DIGITS);

  logic [NUM_KEYS-1:0]  r_sync1;
  logic [NUM_KEYS-1:0]  r_ks;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_KEYS-1:0]  r_cand;
  logic [NUM_KEYS-1:0]  w_cand_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_CNT_W-1:0]   w_cnt_nxt;
  logic                 w_eval;

  logic [c_REG_W-1:0]   r_digits;
  logic [c_REG_W-1:0]   w_shifted;
  logic [c_COUNT_W-1:0] r_count;
  logic                 r_dv;
  logic                 r_err;
  logic                 w_dv_nxt;
  logic                 w_err_nxt;
  logic                 w_shift;
  logic                 w_full;

  logic [DIGIT_W-1:0]   w_value;
  logic                 w_onehot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_ks    <= '0;
    end else begin
      r_sync1 <= keys;
      r_ks    <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cand  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Press is evaluated on the edge that leaves DEB_PRESS for HELD
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    w_eval      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ks != '0) begin
          w_state_nxt = S_DEB_PRESS;
          w_cand_nxt  = r_ks;
          w_cnt_nxt   = '0;
        end
      end
      S_DEB_PRESS: begin
        if (r_ks != r_cand) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_DEB_LAST) begin
          w_state_nxt = S_HELD;
          w_eval      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (r_ks == '0) begin
          w_state_nxt = S_DEB_REL;
          w_cnt_nxt   = '0;
        end
      end
      S_DEB_REL: begin
        if (r_ks != '0) begin
          w_state_nxt = S_HELD;
        end else if (r_cnt == c_DEB_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  onehot_to_bin #(
    .NUM_KEYS (NUM_KEYS)
  ) u_enc (
    .i_cand   (r_cand),
    .o_value  (w_value),
    .o_onehot (w_onehot)
  );

  generate
    if (DIGITS == 1) begin : g_shift_single
      assign w_shifted = w_value;
    end else begin : g_shift_multi
      assign w_shifted = {r_digits[c_REG_W-DIGIT_W-1:0], w_value};
    end
  endgenerate

  assign w_full = (r_count == c_FULL_CNT);

  // clr wins over a simultaneous press and silences both strobes
  always_comb begin
    w_dv_nxt  = 1'b0;
    w_err_nxt = 1'b0;
    w_shift   = 1'b0;
    if (w_eval && !clr) begin
      if (!w_onehot) begin
        w_err_nxt = 1'b1;
      end else if (!en) begin
        if (w_full) begin
          w_err_nxt = 1'b1;
        end else begin
          w_dv_nxt = 1'b1;
          w_shift  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= {DIGITS{DIGIT_CLR}};
      r_count  <= '0;
      r_dv     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_dv  <= w_dv_nxt;
      r_err <= w_err_nxt;
      if (clr) begin
        r_digits <= {DIGITS{DIGIT_CLR}};
        r_count  <= '0;
      end else if (w_shift) begin
        r_digits <= w_shifted;
        r_count  <= r_count + 1'b1;
      end
    end
  end

  assign digits = r_digits;
  assign count  = r_count;
  assign full   = w_full;
  assign dv     = r_dv;
  assign err    = r_err;

endmodule : keypad_digit_entry
`default_nettype wire

// File: tb/tb_keypad_digit_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_digit_entry
//  Description : Self-checking bench for keypad_digit_entry (10 keys, 4 digits)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_digit_entry;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  keys;
  logic        en;
  logic        clr;
  logic [15:0] digits;
  logic [2:0]  count;
  logic        full;
  logic        dv;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  int dv_seen = 0;
  int err_seen = 0;
  int overlap = 0;
  int wide = 0;
  logic prev_dv = 1'b0;
  logic prev_err = 1'b0;

  int model_q[$];

  keypad_digit_entry #(
    .NUM_KEYS        (10),
    .DIGITS          (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .keys   (keys),
    .en     (en),
    .clr    (clr),
    .digits (digits),
    .count  (count),
    .full   (full),
    .dv     (dv),
    .err    (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dv) dv_seen++;
    if (err) err_seen++;
    if (dv && err) overlap++;
    if ((dv && prev_dv) || (err && prev_err)) wide++;
    prev_dv  <= dv;
    prev_err <= err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  // Clean press: hold stable, release, and report strobes seen meanwhile
  task automatic press(input logic [9:0] k, input logic e, output int ndv, output int nerr);
    int d0;
    int e0;
    d0 = dv_seen;
    e0 = err_seen;
    en = e;
    keys = k;
    repeat (20) @(negedge clk);
    keys = '0;
    repeat (12) @(negedge clk);
    ndv  = dv_seen - d0;
    nerr = err_seen - e0;
  endtask

  // Reference: list of entered digits, oldest first
  task automatic model_press(input logic [9:0] k, input logic e, output int edv, output int eerr);
    edv = 0;
    eerr = 0;
    if ($countones(k) != 1) begin
      eerr = 1;
    end else if (!e) begin
      if (model_q.size() == 4) begin
        eerr = 1;
      end else begin
        for (int i = 0; i < 10; i++) if (k[i]) model_q.push_back(i);
        edv = 1;
      end
    end
  endtask

  function automatic logic [15:0] model_digits();
    logic [15:0] v;
    v = '0;
    foreach (model_q[i]) v = (v << 4) | 16'(model_q[i]);
    return v;
  endfunction

  typedef struct {
    logic        clr_first;
    logic [9:0]  k;
    logic        e;
    int          exp_dv;
    int          exp_err;
    logic [15:0] exp_dig;
    int          exp_cnt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int ndv;
    int nerr;
    int edv;
    int eerr;
    logic dv_at[1:8];
    logic [9:0] k;
    logic e;

    tbl[0] = '{1'b1, 10'h008, 1'b0, 1, 0, 16'h0003, 1};
    tbl[1] = '{1'b1, 10'h002, 1'b0, 1, 0, 16'h0001, 1};
    tbl[2] = '{1'b0, 10'h004, 1'b0, 1, 0, 16'h0012, 2};
    tbl[3] = '{1'b0, 10'h008, 1'b0, 1, 0, 16'h0123, 3};
    tbl[4] = '{1'b0, 10'h010, 1'b0, 1, 0, 16'h1234, 4};
    tbl[5] = '{1'b0, 10'h020, 1'b0, 0, 1, 16'h1234, 4};
    tbl[6] = '{1'b1, 10'h024, 1'b0, 0, 1, 16'h0000, 0};
    tbl[7] = '{1'b0, 10'h010, 1'b1, 0, 0, 16'h0000, 0};
    tbl[8] = '{1'b0, 10'h001, 1'b0, 1, 0, 16'h0000, 1};
    tbl[9] = '{1'b0, 10'h200, 1'b0, 1, 0, 16'h0009, 2};

    rst_n = 1'b0;
    keys = '0;
    en = 1'b0;
    clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_digits", 32'(digits), 0);
    chk("reset_count", 32'(count), 0);
    chk("reset_full", 32'(full), 0);
    chk("reset_dv_err", {30'd0, dv, err}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: dv must appear right after the 7th edge counting the first sampling edge
    keys = 10'h008;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      dv_at[i] = dv;
    end
    chk("latency_edge6", 32'(dv_at[6]), 0);
    chk("latency_edge7", 32'(dv_at[7]), 1);
    chk("latency_edge8", 32'(dv_at[8]), 0);
    repeat (12) @(negedge clk);
    keys = '0;
    repeat (12) @(negedge clk);
    chk("first_digits", 32'(digits), 32'h0003);
    chk("first_count", 32'(count), 1);

    for (int t = 0; t < 10; t++) begin
      if (tbl[t].clr_first) do_clr();
      press(tbl[t].k, tbl[t].e, ndv, nerr);
      chk($sformatf("tbl%0d_dv", t), 32'(ndv), 32'(tbl[t].exp_dv));
      chk($sformatf("tbl%0d_err", t), 32'(nerr), 32'(tbl[t].exp_err));
      chk($sformatf("tbl%0d_digits", t), 32'(digits), 32'(tbl[t].exp_dig));
      chk($sformatf("tbl%0d_count", t), 32'(count), 32'(tbl[t].exp_cnt));
      chk($sformatf("tbl%0d_full", t), 32'(full), (tbl[t].exp_cnt == 4) ? 32'd1 : 32'd0);
    end

    // Bouncing key 7, then stable
    do_clr();
    begin
      int d0;
      d0 = dv_seen;
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
        keys = (i % 2 == 0) ? 10'h080 : 10'h000;
        repeat (2) @(negedge clk);
      end
      keys = 10'h080;
      repeat (20) @(negedge clk);
      keys = '0;
      repeat (12) @(negedge clk);
      chk("bounce_dv", 32'(dv_seen - d0), 1);
      chk("bounce_digits", 32'(digits), 32'h0007);
    end

    // clr on the same edge a press is accepted
    begin
      int d0;
      int e0;
      d0 = dv_seen;
      e0 = err_seen;
      keys = 10'h020;
      repeat (6) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_same_dv", 32'(dv), 0);
      chk("clr_same_digits", 32'(digits), 0);
      chk("clr_same_count", 32'(count), 0);
      repeat (14) @(negedge clk);
      keys = '0;
      repeat (12) @(negedge clk);
      chk("clr_same_strobes", 32'((dv_seen - d0) + (err_seen - e0)), 0);
    end

    // Reset mid-debounce with key 9 held
    press(10'h040, 1'b0, ndv, nerr);
    chk("pre_reset_digits", 32'(digits), 32'h0006);
    begin
      int d0;
      keys = 10'h200;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_digits", 32'(digits), 0);
      chk("async_reset_count", {29'd0, full, count}, 0);
      chk("async_reset_strobes", {30'd0, dv, err}, 0);
      @(negedge clk);
      d0 = dv_seen;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      keys = '0;
      repeat (12) @(negedge clk);
      chk("post_reset_dv", 32'(dv_seen - d0), 1);
      chk("post_reset_digits", 32'(digits), 32'h0009);
      chk("post_reset_count", 32'(count), 1);
    end

    // Randomized clean presses against the digit-list model
    do_clr();
    model_q.delete();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        do_clr();
        model_q.delete();
      end
      if ($urandom_range(0, 4) == 0) k = 10'($urandom_range(1, 1023));
      else k = 10'(1) << $urandom_range(0, 9);
      e = ($urandom_range(0, 3) == 0);
      model_press(k, e, edv, eerr);
      press(k, e, ndv, nerr);
      chk($sformatf("rnd%0d_dv", n), 32'(ndv), 32'(edv));
      chk($sformatf("rnd%0d_err", n), 32'(nerr), 32'(eerr));
      chk($sformatf("rnd%0d_digits", n), 32'(digits), 32'(model_digits()));
      chk($sformatf("rnd%0d_count", n), 32'(count), 32'(model_q.size()));
      chk($sformatf("rnd%0d_full", n), 32'(full), (model_q.size() == 4) ? 32'd1 : 32'd0);
    end

    chk("dv_err_overlap", 32'(overlap), 0);
    chk("strobe_width", 32'(wide), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_keypad_digit_entry
`default_nettype wire
